// File: rtl/key_buffer.sv
// Keyboard type-ahead FIFO with typematic auto-repeat of the most recently pressed key.
// Presses and repeat ticks share a single push port; the CPU pops one character per read strobe.
module key_buffer #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned REPEAT_DELAY  = 5000000,
    parameter int unsigned REPEAT_PERIOD = 1000000
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [6:0]                       i_ascii_code,
    input  logic                             i_key_press,
    input  logic                             i_key_release,
    input  logic                             i_rd,
    output logic [6:0]                       o_data,
    output logic                             o_ready,
    output logic [$clog2(DEPTH+1)-1:0]       o_count,
    output logic                             o_overflow
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned MAXR = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CW   = $clog2(MAXR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      held_q, held_d;

    logic [6:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [6:0]      data_q, data_d;
    logic            ready_q, ready_d;

    logic            tick;
    logic            rel_match;
    logic            rep_push;
    logic            pop_acc;
    logic            push_acc;
    logic            full;
    logic [6:0]      push_data;

    // Repeat FSM: a press always restarts the delay on the new code; a matching release stops it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        tick      = 1'b0;
        rel_match = 1'b0;
        rep_push  = 1'b0;
        unique case (state_q)
            ST_DELAY:  tick = (cnt_q == CW'(REPEAT_DELAY - 1));
            ST_REPEAT: tick = (cnt_q == CW'(REPEAT_PERIOD - 1));
            default:   tick = 1'b0;
        endcase
        rel_match = i_key_release && !i_key_press && (state_q != ST_IDLE) &&
                    (i_ascii_code == held_q);
        if (i_key_press) begin
            state_d = ST_DELAY;
            held_d  = i_ascii_code;
            cnt_d   = '0;
        end else if (rel_match) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (tick) begin
            state_d  = ST_REPEAT;
            cnt_d    = '0;
            rep_push = 1'b1;
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // FIFO bookkeeping; o_data is registered as the next-cycle head entry.
    always_comb begin
        full      = (count_q == CNTW'(DEPTH));
        pop_acc   = i_rd && (count_q != '0);
        push_data = i_key_press ? i_ascii_code : held_q;
        push_acc  = (i_key_press || rep_push) && (!full || pop_acc);
        wr_ptr_d  = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (i_key_press && full && !pop_acc) begin
            ovf_d = 1'b1;
        end else if (pop_acc) begin
            ovf_d = 1'b0;
        end
        data_d = data_q;
        if (count_d == '0) begin
            data_d = 7'h00;
        end else if (pop_acc) begin
            data_d = (count_q == CNTW'(1)) ? push_data : mem_q[rd_ptr_q + PW'(1)];
        end else if (count_q == '0) begin
            data_d = push_data;
        end
        ready_d = (count_d != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            held_q   <= 7'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            data_q   <= 7'h00;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign o_data     = data_q;
    assign o_ready    = ready_q;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_key_buffer.sv
// Bench for key_buffer: directed scenarios plus random traffic against a queue-based model
// that tracks repeat times as absolute edge numbers.
module tb_key_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned RD_D  = 20;
    localparam int unsigned RP_P  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] code = 7'h00;
    logic       press = 1'b0;
    logic       rel = 1'b0;
    logic       rd = 1'b0;
    logic [6:0] o_data;
    logic       o_ready;
    logic [3:0] o_count;
    logic       o_overflow;

    int total = 0;
    int bad = 0;

    logic [6:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_active = 1'b0;
    logic [6:0] m_held = 7'h00;
    longint     e = 0;
    longint     next_rep = 0;

    key_buffer #(.DEPTH(DEPTH), .REPEAT_DELAY(RD_D), .REPEAT_PERIOD(RP_P)) dut (
        .i_clk(clk), .i_rst(rst), .i_ascii_code(code), .i_key_press(press),
        .i_key_release(rel), .i_rd(rd), .o_data(o_data), .o_ready(o_ready),
        .o_count(o_count), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One clock edge of behaviour, written from the keyboard-buffer rules rather than the RTL.
    task automatic model_edge(input bit p, input bit r, input bit rdx, input logic [6:0] c);
        bit t;
        e++;
        t = m_active && (e == next_rep);
        if (rdx && q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
        if (p) begin
            if (q.size() < DEPTH) q.push_back(c);
            else m_ovf = 1'b1;
            m_held   = c;
            m_active = 1'b1;
            next_rep = e + RD_D;
        end else if (r && m_active && c == m_held) begin
            m_active = 1'b0;
        end else if (t) begin
            if (q.size() < DEPTH) q.push_back(m_held);
            next_rep = e + RP_P;
        end
    endtask

    task automatic compare_all();
        check("data", int'(o_data), (q.size() > 0) ? int'(q[0]) : 0);
        check("ready", int'(o_ready), (q.size() > 0) ? 1 : 0);
        check("count", int'(o_count), q.size());
        check("overflow", int'(o_overflow), int'(m_ovf));
    endtask

    // Inputs are already set (at a negedge); apply one edge, then compare at the next negedge.
    task automatic step();
        @(posedge clk);
        model_edge(press, rel, rd, code);
        @(negedge clk);
        compare_all();
        press = 1'b0;
        rel   = 1'b0;
        rd    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_press(input logic [6:0] c);
        code = c; press = 1'b1; step();
    endtask

    task automatic do_release(input logic [6:0] c);
        code = c; rel = 1'b1; step();
    endtask

    task automatic do_read();
        rd = 1'b1; step();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (q.size() > 0) do_read();
        end
    endtask

    // Asynchronous reset asserted a few ns after an idle edge.
    task automatic do_reset();
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0, 7'h00);
        #2 rst = 1'b1;
        #1;
        check("rst_data", int'(o_data), 0);
        check("rst_ready", int'(o_ready), 0);
        check("rst_count", int'(o_count), 0);
        check("rst_ovf", int'(o_overflow), 0);
        q.delete();
        m_ovf = 1'b0;
        m_active = 1'b0;
        m_held = 7'h00;
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        logic [6:0] last;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Reset, single press, single read.
        idle(3);
        do_reset();
        do_press(7'h61);
        check("press_data", int'(o_data), 8'h61);
        check("press_count", int'(o_count), 1);
        do_release(7'h61);
        do_read();
        check("pop_ready", int'(o_ready), 0);
        check("pop_data", int'(o_data), 0);

        // Overflow on the ninth press; reads return in order and clear the flag.
        for (int i = 0; i < 9; i++) do_press(7'(8'h41 + i));
        do_release(7'h49);
        check("ovf_count", int'(o_count), 8);
        check("ovf_flag", int'(o_overflow), 1);
        for (int i = 0; i < 8; i++) begin
            check("ovf_order", int'(o_data), 8'h41 + i);
            do_read();
            if (i == 0) check("ovf_clear", int'(o_overflow), 0);
        end

        // Auto-repeat: press at edge 0, release at edge 38.
        do_press(7'h7A);
        idle(37);
        do_release(7'h7A);
        check("rep_count", int'(o_count), 5);
        idle(10);
        check("rep_stopped", int'(o_count), 5);
        drain();

        // Non-matching release does not stop the repeat.
        do_press(7'h7A);
        idle(9);
        do_release(7'h61);
        idle(15);
        check("rel_other", int'(o_count), 3);
        do_release(7'h7A);
        drain();

        // A new press restarts the delay on the newest key.
        do_press(7'h61);
        idle(21);
        do_press(7'h62);
        idle(19);
        check("newkey_pre", int'(o_count), 3);
        idle(1);
        check("newkey_post", int'(o_count), 4);
        do_release(7'h62);
        drain();

        // Release coinciding with the first repeat tick.
        do_press(7'h55);
        idle(19);
        do_release(7'h55);
        check("rel_tick", int'(o_count), 1);
        drain();

        // Held key while full: repeats dropped silently; read+press when full.
        do_press(7'h70);
        idle(60);
        check("full_count", int'(o_count), 8);
        check("full_ovf", int'(o_overflow), 0);
        code = 7'h71; press = 1'b1; rd = 1'b1; step();
        check("rdpress_count", int'(o_count), 8);
        check("rdpress_ovf", int'(o_overflow), 0);
        do_release(7'h71);
        last = 7'h00;
        for (int i = 0; i < 8; i++) begin
            last = o_data;
            do_read();
        end
        check("rdpress_tail", int'(last), 8'h71);

        // Reset mid-repeat, then nothing appears without a new press.
        do_press(7'h33);
        idle(30);
        do_reset();
        idle(100);
        check("midrst_count", int'(o_count), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                code  = 7'(8'h60 + $urandom_range(0, 3));
                press = ($urandom_range(0, 7) == 0);
                rel   = ($urandom_range(0, 5) == 0);
                rd    = ($urandom_range(0, 2) == 0);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_buffer.md
# key_buffer

Keyboard type-ahead buffer with typematic auto-repeat. It sits directly downstream of the PS/2-to-ASCII keyboard decoder and consumes that block's 7-bit ASCII code and its one-cycle press/release strobes. It queues keystrokes in a small FIFO and generates repeat keystrokes while a key is held. The CPU keyboard port reads the queue one character at a time.

## Interface
- DEPTH, 8: FIFO entries. Must be a power of 2 and ≥2.
- REPEAT_DELAY, 5000000: cycles from press to first repeat (500 ms at 10 MHz).
- REPEAT_PERIOD, 1000000: cycles between subsequent repeats (100 ms at 10 MHz). Must be ≥2.
- i_clk  in  1  system clock. Single clock domain.
- i_rst  in  1  reset, asynchronous, active-high.
- i_ascii_code  in  7  decoder ASCII code. Valid only when a strobe is high.
- i_key_press  in  1  one-cycle key-press strobe.
- i_key_release  in  1  one-cycle key-release strobe.
- i_rd  in  1  CPU read strobe, one cycle. Pops the head entry.
- o_data  out  7  head entry; 7'h00 when the FIFO is empty.
- o_ready  out  1  FIFO non-empty.
- o_count  out  $clog2(DEPTH+1)  number of stored entries.
- o_overflow  out  1  sticky: a key press was dropped because the FIFO was full.

## Operation
- FIFO: DEPTH x 7 storage, with write and read pointers of $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH. A separate count register tracks occupancy.
- Push sources:
  - a press strobe (i_ascii_code);
  - a repeat tick (the held code).
  - At most one push per cycle. If a press and a repeat tick fall in the same cycle, the press wins and that tick is discarded.
- Press while full: the entry is dropped and o_overflow is set to 1.
- Repeat tick while full: the entry is dropped silently. o_overflow is unchanged and repeat timing continues.
- i_rd while empty: ignored, with no pointer or count change.
- Push and i_rd in the same cycle with the FIFO non-empty: both take effect and count is unchanged. This applies when full too: the read frees a slot, so the push is accepted and o_overflow is not set.
- o_overflow clears on any accepted i_rd. If that same cycle also sets it, set wins.
- Repeat FSM states:
  - IDLE → DELAY on a press strobe: latch the held code, counter←0.
  - DELAY: counter increments each cycle. When counter==REPEAT_DELAY-1, push the held code, counter←0, → REPEAT.
  - REPEAT: counter increments. When counter==REPEAT_PERIOD-1, push the held code, counter←0.
  - A press in DELAY or REPEAT latches the new code, counter←0, → DELAY (newest key repeats).
  - A release whose code equals the held code → IDLE from DELAY or REPEAT. A release with any other code is ignored.
  - A release and a repeat tick in the same cycle: the release wins and no push occurs.
  - Press and release strobes in the same cycle: treat as a press only.
- Counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- All ASCII codes repeat, including control codes.

## Timing
- Reset (asynchronous, at any time, including mid-repeat):
  - o_data=0, o_ready=0, o_count=0, o_overflow=0;
  - pointers=0, FSM=IDLE, counter=0, held code=0.
- All outputs are registered or derived from registers. There is no combinational path from inputs to outputs.
- Push latency: a strobe sampled at edge t makes o_ready, o_count and o_data valid after edge t.
- Pop: i_rd sampled at edge t advances o_data to the next entry (or 7'h00) after edge t.
- Repeat timing, with the press sampled at edge 0: repeat pushes occur at edges REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, REPEAT_DELAY+2·REPEAT_PERIOD, and so on, until a matching release is sampled.
- Entry order is strictly FIFO across press and repeat pushes.

## Test plan
- Reset: assert i_rst asynchronously mid-cycle → all outputs 0 immediately. Then press 7'h61 → o_ready=1, o_data=7'h61, o_count=1 the next cycle. Then i_rd → o_ready=0, o_data=7'h00.
- Overflow: with DEPTH=8, press 9 distinct codes 7'h41..7'h49 with no reads → o_count=8, o_overflow=1. Reads return 7'h41..7'h48 in order. o_overflow clears on the first read.
- Auto-repeat: with REPEAT_DELAY=20 and REPEAT_PERIOD=5, press 7'h7A at edge 0 and release 7'h7A at edge 38 → exactly 5 entries (edges 0, 20, 25, 30, 35), all 7'h7A.
- Repeat edge cases:
  - release 7'h61 while 7'h7A is held → repeats continue;
  - press 7'h62 at edge 22 while 7'h61 is held → next repeat is 7'h62 at edge 42;
  - release coinciding with a repeat tick → no extra entry.
- Full FIFO: hold a key with the FIFO full → repeats are dropped and o_overflow stays 0. i_rd and a press in the same cycle while full → o_count stays 8, o_overflow=0, and the new code lands at the tail.
- Mid-repeat reset: assert i_rst while in REPEAT → FIFO empty, FSM IDLE. With no new press, no further entries appear for 100 cycles after reset deasserts.
